// File: rtl/capiano_pkg.sv
// Shared definitions for the camera-piano pixel path: RGB333 field layout,
// bus widths, the key scanner state encoding and the luma-sum helper.
package capiano_pkg;

    localparam int PIX_W  = 9;
    localparam int ADDR_W = 32;
    localparam int CH_W   = 3;
    localparam int R_LSB  = 6;
    localparam int G_LSB  = 3;
    localparam int B_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_EVAL  = 2'd3
    } scan_state_e;

    // Cheap brightness estimate: plain sum of the three 3-bit channels (0..21).
    function automatic logic [4:0] sum_rgb333(input logic [PIX_W-1:0] pix);
        return 5'(pix[R_LSB +: CH_W]) + 5'(pix[G_LSB +: CH_W]) + 5'(pix[B_LSB +: CH_W]);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Per-key debounce for the scanner's raw bitmap. A key only changes after
// DEB_FRAMES consecutive evaluations disagree with its current value; one
// agreeing evaluation restarts that key's count.
module key_debouncer #(
    parameter int NUM_KEYS   = 8,
    parameter int DEB_FRAMES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                eval,
    input  logic [NUM_KEYS-1:0] raw,
    output logic [NUM_KEYS-1:0] keys
);

    localparam int               CNT_W    = $clog2(DEB_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_FRAMES - 1);

    logic [CNT_W-1:0] agree [NUM_KEYS];

    // Count disagreeing evaluations per key; flip the key on the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keys <= '0;
            for (int i = 0; i < NUM_KEYS; i++) agree[i] <= '0;
        end else if (eval) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (raw[i] == keys[i]) begin
                    agree[i] <= '0;
                end else if (agree[i] == CNT_LAST) begin
                    keys[i]  <= raw[i];
                    agree[i] <= '0;
                end else begin
                    agree[i] <= agree[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/key_scanner.sv
// Scans the key strip of the stored frame after every completed frame and
// reports which piano keys are covered (dark). Reads one pixel per cycle on a
// 1-cycle-latency memory port; the column's key index travels one cycle
// behind the address so it lines up with q.
// Optional feature: define KEY_DEBOUNCE_EN to debounce keys over DEB_FRAMES scans.
module key_scanner
    import capiano_pkg::*;
#(
    parameter int NUM_KEYS   = 8,
    parameter int IMG_W      = 320,
    parameter int ROI_Y0     = 160,
    parameter int ROI_Y1     = 224,
    parameter int KEY_W      = 40,
    parameter int LUMA_TH    = 6,
    parameter int PRESS_TH   = 800,
    parameter int DEB_FRAMES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_done,
    output logic [ADDR_W-1:0]   addr,
    input  logic [PIX_W-1:0]    q,
    output logic [NUM_KEYS-1:0] keys,
    output logic                keys_valid,
    output logic                busy,
    output scan_state_e         dbg_state
);

    localparam int X_W  = $clog2(IMG_W);
    localparam int Y_W  = $clog2(ROI_Y1);
    localparam int KS_W = $clog2(KEY_W + 1);
    localparam int KI_W = $clog2(NUM_KEYS + 1);

    localparam logic [X_W-1:0]    X_LAST     = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]    Y_FIRST    = Y_W'(ROI_Y0);
    localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(ROI_Y1 - 1);
    localparam logic [KS_W-1:0]   SUB_LAST   = KS_W'(KEY_W - 1);
    localparam logic [KI_W-1:0]   KEY_END    = KI_W'(NUM_KEYS);
    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(ROI_Y0 * IMG_W);
    localparam logic [4:0]        LUMA_LIM   = 5'(LUMA_TH);
    localparam logic [15:0]       PRESS_LIM  = 16'(PRESS_TH);

    if (ROI_Y1 <= ROI_Y0 || DEB_FRAMES < 1) begin : g_bad_cfg
        $error("key_scanner: invalid parameter set");
    end

    scan_state_e         state, state_d;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [KS_W-1:0]     key_sub;
    logic [KI_W-1:0]     key_idx;   // saturates at NUM_KEYS past the last key
    logic                pix_cnt;   // pixel arriving on q belongs to a key
    logic [KI_W-1:0]     pix_key;
    logic [15:0]         cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] raw;
    logic                start, last_pix, eval, pix_dark;

    assign start     = (state == ST_IDLE) && frame_done;
    assign last_pix  = (x == X_LAST) && (y == Y_LAST);
    assign eval      = (state == ST_EVAL);
    assign pix_dark  = sum_rgb333(q) < LUMA_LIM;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_d;
    end

    // Next state: one pass over the ROI, one cycle to catch the last pixel, one to evaluate.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (frame_done) state_d = ST_SCAN;
            ST_SCAN:  if (last_pix)   state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_EVAL;
            ST_EVAL:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Raster walk: the ROI rows are contiguous in memory so addr just increments,
    // while x/y and the key sub-counter track where that address sits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr    <= '0;
            x       <= '0;
            y       <= '0;
            key_sub <= '0;
            key_idx <= '0;
        end else if (start) begin
            addr    <= ADDR_FIRST;
            x       <= '0;
            y       <= Y_FIRST;
            key_sub <= '0;
            key_idx <= '0;
        end else if (state == ST_SCAN && !last_pix) begin
            addr <= addr + 1'b1;
            if (x == X_LAST) begin
                x       <= '0;
                y       <= y + 1'b1;
                key_sub <= '0;
                key_idx <= '0;
            end else begin
                x <= x + 1'b1;
                if (key_sub == SUB_LAST) begin
                    key_sub <= '0;
                    if (key_idx != KEY_END) key_idx <= key_idx + 1'b1;
                end else begin
                    key_sub <= key_sub + 1'b1;
                end
            end
        end
    end

    // Delay the key index to meet q, then count dark pixels per key (saturating).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt <= 1'b0;
            pix_key <= '0;
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
        end else begin
            pix_cnt <= (state == ST_SCAN) && (key_idx != KEY_END);
            pix_key <= key_idx;
            if (start) begin
                for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
            end else if (pix_cnt && pix_dark) begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (pix_key == KI_W'(i) && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Per-key press decision from the finished counts.
    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_KEYS; i++) raw[i] = (cnt[i] >= PRESS_LIM);
    end

    // Result strobe leaves EVAL together with the key update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) keys_valid <= 1'b0;
        else      keys_valid <= eval;
    end

`ifdef KEY_DEBOUNCE_EN
    key_debouncer #(
        .NUM_KEYS   (NUM_KEYS),
        .DEB_FRAMES (DEB_FRAMES)
    ) u_debouncer (
        .clk  (clk),
        .rst  (rst),
        .eval (eval),
        .raw  (raw),
        .keys (keys)
    );
`else
    // Without debounce the bitmap follows every evaluation directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      keys <= '0;
        else if (eval) keys <= raw;
    end
`endif

endmodule
